// File: rtl/alu_pkt_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : alu_pkt_pkg                                                   |
// | Purpose  : Shared types and constants for the packet sequencer:          |
// |            controller state encoding, opcodes, header size and the       |
// |            payload-length helper.                                        |
// | Options  : ALU_SUB_EN (consumers decide whether OP_SUB is honoured)      |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
package alu_pkt_pkg;

  typedef enum logic [2:0] {
    HDR_OP  = 3'd0,
    HDR_RSV = 3'd1,
    HDR_LLO = 3'd2,
    HDR_LHI = 3'd3,
    ECHO    = 3'd4,
    ACC     = 3'd5,
    RESULT  = 3'd6,
    DRAIN   = 3'd7
  } state_e;

  localparam logic [7:0]  OP_ECHO   = 8'hEC;
  localparam logic [7:0]  OP_ADD    = 8'h01;
  localparam logic [7:0]  OP_SUB    = 8'h02;
  localparam logic [15:0] HDR_BYTES = 16'd4;

  // The length field includes the header itself; anything shorter than a
  // header carries no payload.
  function automatic logic [15:0] calc_pay(input logic [15:0] len);
    return (len < HDR_BYTES) ? 16'd0 : (len - HDR_BYTES);
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_word_acc.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : alu_word_acc                                                  |
// | Purpose  : Assembles payload bytes LSB-first into WORD_W-bit words and   |
// |            folds each completed word into a running accumulator.         |
// | Options  : ALU_SUB_EN - adds the i_sub port and a subtract path          |
// | Ports    : clk_i, reset_i  clock / synchronous active-high reset         |
// |            i_sub           (ALU_SUB_EN only) subtract later words        |
// |            i_clear         start of packet: clear byte index and acc     |
// |            i_byte, i_valid payload byte and its strobe                   |
// |            i_first         word completing now is the first operand      |
// |            o_acc           accumulator value                             |
// |            o_word_done     a word completes on this byte                 |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module alu_word_acc
  import alu_pkt_pkg::*;
#(
  parameter int WORD_W = 32
) (
  input  logic              clk_i,
  input  logic              reset_i,
`ifdef ALU_SUB_EN
  input  logic              i_sub,
`endif
  input  logic              i_clear,
  input  logic [7:0]        i_byte,
  input  logic              i_valid,
  input  logic              i_first,
  output logic [WORD_W-1:0] o_acc,
  output logic              o_word_done
);

  localparam int NB    = WORD_W / 8;
  localparam int CNT_W = (NB > 1) ? $clog2(NB) : 1;

  logic [CNT_W-1:0]  r_cnt;
  logic [WORD_W-1:0] r_acc;
  logic [WORD_W-1:0] w_word;
  logic [WORD_W-1:0] w_next;
  logic              w_last;

  assign w_last = (r_cnt == CNT_W'(NB - 1));

  // New bytes enter at the top, so after NB bytes the first one sits in the
  // least significant position.
  generate
    if (NB == 1) begin : g_single
      assign w_word = i_byte;
    end else begin : g_multi
      logic [WORD_W-9:0] r_shift;
      always_ff @(posedge clk_i) begin
        if (reset_i || i_clear) begin
          r_shift <= '0;
        end else if (i_valid) begin
          r_shift <= w_word[WORD_W-1:8];
        end
      end
      assign w_word = {i_byte, r_shift};
    end
  endgenerate

`ifdef ALU_SUB_EN
  assign w_next = i_first ? w_word : (i_sub ? (r_acc - w_word) : (r_acc + w_word));
`else
  assign w_next = i_first ? w_word : (r_acc + w_word);
`endif

  always_ff @(posedge clk_i) begin
    if (reset_i || i_clear) begin
      r_cnt <= '0;
      r_acc <= '0;
    end else if (i_valid) begin
      if (w_last) begin
        r_cnt <= '0;
        r_acc <= w_next;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign o_acc       = r_acc;
  assign o_word_done = i_valid & w_last;

endmodule
`default_nettype wire

// File: rtl/alu_packet_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : alu_packet_ctrl                                               |
// | Purpose  : Packet sequencer between the UART byte streams and the        |
// |            accumulate datapath: parses a 4-byte header, echoes,          |
// |            accumulates or drains the payload, streams results back.      |
// | Options  : ALU_SUB_EN - recognise OP_SUB (first operand minus others)    |
// | Ports    : clk_i, reset_i           clock / sync active-high reset       |
// |            rx_tdata_i/tvalid_i/tready_o   byte stream from uart_rx       |
// |            tx_tdata_o/tvalid_o/tready_i   byte stream to uart_tx         |
// |            busy_o                   high outside the opcode state        |
// |            bad_op_o                 one-cycle pulse on unknown opcode    |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module alu_packet_ctrl #(
  parameter int WORD_W = 32
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic [7:0] rx_tdata_i,
  input  logic       rx_tvalid_i,
  output logic       rx_tready_o,
  output logic [7:0] tx_tdata_o,
  output logic       tx_tvalid_o,
  input  logic       tx_tready_i,
  output logic       busy_o,
  output logic       bad_op_o
);

  import alu_pkt_pkg::*;

  localparam int NB    = WORD_W / 8;
  localparam int IDX_W = $clog2(NB) + 1;

  state_e            r_state;
  state_e            w_state_nxt;
  logic [7:0]        r_op;
  logic [7:0]        r_len_lo;
  logic [15:0]       r_pay;
  logic [15:0]       r_cnt;
  logic [7:0]        r_tx_data;
  logic              r_tx_valid;
  logic              r_bad_op;
  logic              r_first_word;
  logic [IDX_W-1:0]  r_res_idx;

  logic              w_rx_ready;
  logic              w_rx_fire;
  logic              w_tx_fire;
  logic [15:0]       w_pay_hdr;
  logic              w_op_echo;
  logic              w_op_sub;
  logic              w_op_arith;
  logic              w_pay_last;
  logic              w_res_more;
  logic [7:0]        w_res_byte;
  logic              w_acc_clear;
  logic              w_acc_valid;
  logic              w_word_done;
  logic [WORD_W-1:0] w_acc;

  assign w_rx_fire  = rx_tvalid_i & rx_tready_o;
  assign w_tx_fire  = r_tx_valid & tx_tready_i;
  assign w_pay_hdr  = calc_pay({rx_tdata_i, r_len_lo});
  assign w_op_echo  = (r_op == OP_ECHO);
`ifdef ALU_SUB_EN
  assign w_op_sub   = (r_op == OP_SUB);
`else
  assign w_op_sub   = 1'b0;
`endif
  assign w_op_arith = (r_op == OP_ADD) | w_op_sub;
  assign w_pay_last = (r_cnt == (r_pay - 16'd1));
  assign w_res_more = (r_res_idx != IDX_W'(NB));
  assign w_res_byte = 8'(w_acc >> {r_res_idx, 3'b000});

  // Ready is decoded from registered state only, so tx_tready_i never
  // reaches rx_tready_o combinationally. It is forced low while in reset.
  always_comb begin
    w_state_nxt = r_state;
    w_rx_ready  = 1'b0;
    case (r_state)
      HDR_OP: begin
        w_rx_ready = 1'b1;
        if (w_rx_fire) w_state_nxt = HDR_RSV;
      end
      HDR_RSV: begin
        w_rx_ready = 1'b1;
        if (w_rx_fire) w_state_nxt = HDR_LLO;
      end
      HDR_LLO: begin
        w_rx_ready = 1'b1;
        if (w_rx_fire) w_state_nxt = HDR_LHI;
      end
      HDR_LHI: begin
        w_rx_ready = 1'b1;
        if (w_rx_fire) begin
          if (w_pay_hdr == 16'd0) w_state_nxt = w_op_arith ? RESULT : HDR_OP;
          else if (w_op_echo)     w_state_nxt = ECHO;
          else if (w_op_arith)    w_state_nxt = ACC;
          else                    w_state_nxt = DRAIN;
        end
      end
      ECHO: begin
        // One-byte buffer: accept only when the tx register is empty and
        // payload bytes remain; leave once the final byte is handed off.
        w_rx_ready = ~r_tx_valid & (r_cnt != r_pay);
        if ((r_cnt == r_pay) && w_tx_fire) w_state_nxt = HDR_OP;
      end
      ACC: begin
        w_rx_ready = 1'b1;
        if (w_rx_fire && w_pay_last) w_state_nxt = RESULT;
      end
      RESULT: begin
        if (w_tx_fire && !w_res_more) w_state_nxt = HDR_OP;
      end
      DRAIN: begin
        w_rx_ready = 1'b1;
        if (w_rx_fire && w_pay_last) w_state_nxt = HDR_OP;
      end
      default: w_state_nxt = HDR_OP;
    endcase
  end

  assign rx_tready_o = w_rx_ready & ~reset_i;

  always_ff @(posedge clk_i) begin
    if (reset_i) r_state <= HDR_OP;
    else         r_state <= w_state_nxt;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_op         <= '0;
      r_len_lo     <= '0;
      r_pay        <= '0;
      r_cnt        <= '0;
      r_tx_data    <= '0;
      r_tx_valid   <= 1'b0;
      r_bad_op     <= 1'b0;
      r_first_word <= 1'b0;
      r_res_idx    <= '0;
    end else begin
      r_bad_op <= 1'b0;
      if (w_tx_fire) r_tx_valid <= 1'b0;
      if (r_state != RESULT) r_res_idx <= '0;

      case (r_state)
        HDR_OP:  if (w_rx_fire) r_op <= rx_tdata_i;
        HDR_LLO: if (w_rx_fire) r_len_lo <= rx_tdata_i;
        HDR_LHI: begin
          if (w_rx_fire) begin
            r_pay        <= w_pay_hdr;
            r_cnt        <= '0;
            r_first_word <= 1'b1;
            r_bad_op     <= (w_pay_hdr != 16'd0) & ~w_op_echo & ~w_op_arith;
          end
        end
        ECHO: begin
          if (w_rx_fire) begin
            r_cnt      <= r_cnt + 16'd1;
            r_tx_data  <= rx_tdata_i;
            r_tx_valid <= 1'b1;
          end
        end
        ACC: begin
          if (w_rx_fire)   r_cnt <= r_cnt + 16'd1;
          if (w_word_done) r_first_word <= 1'b0;
        end
        DRAIN: if (w_rx_fire) r_cnt <= r_cnt + 16'd1;
        RESULT: begin
          if (!r_tx_valid && w_res_more) begin
            r_tx_data  <= w_res_byte;
            r_tx_valid <= 1'b1;
            r_res_idx  <= r_res_idx + IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // The accumulator is cleared on the last header byte of every packet so a
  // zero-length arithmetic packet reports zero.
  assign w_acc_clear = (r_state == HDR_LHI) & w_rx_fire;
  assign w_acc_valid = (r_state == ACC) & w_rx_fire;

  alu_word_acc #(
    .WORD_W (WORD_W)
  ) u_word_acc (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
`ifdef ALU_SUB_EN
    .i_sub       (w_op_sub),
`endif
    .i_clear     (w_acc_clear),
    .i_byte      (rx_tdata_i),
    .i_valid     (w_acc_valid),
    .i_first     (r_first_word),
    .o_acc       (w_acc),
    .o_word_done (w_word_done)
  );

  assign tx_tdata_o  = r_tx_data;
  assign tx_tvalid_o = r_tx_valid;
  assign busy_o      = (r_state != HDR_OP);
  assign bad_op_o    = r_bad_op;

endmodule
`default_nettype wire

// File: tb/tb_alu_packet_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_alu_packet_ctrl                                            |
// | Purpose  : Self-checking bench for alu_packet_ctrl: directed packets     |
// |            from the test plan plus randomized packets against a          |
// |            word-level reference model.                                   |
// | Options  : ALU_SUB_EN - expected behaviour of opcode 02 follows it       |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_alu_packet_ctrl;

  logic       clk_i;
  logic       reset_i;
  logic [7:0] rx_tdata_i;
  logic       rx_tvalid_i;
  logic       rx_tready_o;
  logic [7:0] tx_tdata_o;
  logic       tx_tvalid_o;
  logic       tx_tready_i;
  logic       busy_o;
  logic       bad_op_o;

  alu_packet_ctrl #(.WORD_W(32)) dut (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .rx_tdata_i  (rx_tdata_i),
    .rx_tvalid_i (rx_tvalid_i),
    .rx_tready_o (rx_tready_o),
    .tx_tdata_o  (tx_tdata_o),
    .tx_tvalid_o (tx_tvalid_o),
    .tx_tready_i (tx_tready_i),
    .busy_o      (busy_o),
    .bad_op_o    (bad_op_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int         n_vec;
  int         n_err;
  int         cyc;
  int         rdy_mode;    // 0: always ready, 1: ready 1-of-4, 2: random
  int         bad_cnt;
  int         exp_bad;
  logic [7:0] pkt_q[$];
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  logic       hold_prev;
  logic [7:0] hold_data;

  // Advance one clock: drive after posedge, observe at the following negedge.
  task automatic cycle(input bit drop);
    @(posedge clk_i);
    #1;
    if (drop) rx_tvalid_i = 1'b0;
    cyc++;
    case (rdy_mode)
      0:       tx_tready_i = 1'b1;
      1:       tx_tready_i = ((cyc % 4) == 0);
      default: tx_tready_i = 1'($urandom_range(0, 1));
    endcase
    @(negedge clk_i);
    if (reset_i) begin
      hold_prev = 1'b0;
    end else begin
      if (hold_prev) begin
        n_vec++;
        if (tx_tvalid_o !== 1'b1 || tx_tdata_o !== hold_data) begin
          n_err++;
          $display("FAIL tx_hold: valid=%b data=%h, required valid=1 data=%h",
                   tx_tvalid_o, tx_tdata_o, hold_data);
        end
      end
      hold_prev = tx_tvalid_o & ~tx_tready_i;
      hold_data = tx_tdata_o;
      if (tx_tvalid_o && tx_tready_i) got_q.push_back(tx_tdata_o);
      if (bad_op_o) bad_cnt++;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int t;
    rx_tdata_i  = b;
    rx_tvalid_i = 1'b1;
    t = 0;
    while (!rx_tready_o && t < 300) begin
      cycle(1'b0);
      t++;
    end
    if (!rx_tready_o) begin
      n_vec++;
      n_err++;
      $display("FAIL rx_accept_timeout: byte %h not accepted within %0d cycles", b, t);
      rx_tvalid_i = 1'b0;
    end else begin
      cycle(1'b1);
    end
  endtask

  task automatic run_packet();
    int t;
    got_q.delete();
    bad_cnt = 0;
    foreach (pkt_q[i]) send_byte(pkt_q[i]);
    t = 0;
    while ((busy_o || tx_tvalid_o) && t < 3000) begin
      cycle(1'b0);
      t++;
    end
    n_vec++;
    if (busy_o || tx_tvalid_o) begin
      n_err++;
      $display("FAIL idle_timeout: busy=%b tx_valid=%b, required 0 0", busy_o, tx_tvalid_o);
    end
    repeat (3) cycle(1'b0);
  endtask

  // Reference model: interprets the whole packet at word level.
  task automatic build_expected();
    logic [15:0] len;
    logic [7:0]  op;
    logic [31:0] acc;
    logic [31:0] word;
    int          pay;
    bit          is_sub;
    exp_q.delete();
    exp_bad = 0;
    op  = pkt_q[0];
    len = {pkt_q[3], pkt_q[2]};
    pay = (len < 16'd4) ? 0 : int'(len) - 4;
`ifdef ALU_SUB_EN
    is_sub = (op == 8'h02);
`else
    is_sub = 1'b0;
`endif
    if (op == 8'hEC) begin
      for (int i = 0; i < pay; i++) exp_q.push_back(pkt_q[4+i]);
    end else if (op == 8'h01 || is_sub) begin
      acc = 32'd0;
      for (int w = 0; w < pay / 4; w++) begin
        word = {pkt_q[4+4*w+3], pkt_q[4+4*w+2], pkt_q[4+4*w+1], pkt_q[4+4*w]};
        if (w == 0)      acc = word;
        else if (is_sub) acc = acc - word;
        else             acc = acc + word;
      end
      for (int k = 0; k < 4; k++) exp_q.push_back(8'(acc >> (8 * k)));
    end else begin
      exp_bad = (pay != 0) ? 1 : 0;
    end
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    repeat (3) cycle(1'b0);
    n_vec += 5;
    if (rx_tready_o !== 1'b0) begin n_err++; $display("FAIL rst_rx_tready: got %b, required 0", rx_tready_o); end
    if (tx_tvalid_o !== 1'b0) begin n_err++; $display("FAIL rst_tx_tvalid: got %b, required 0", tx_tvalid_o); end
    if (tx_tdata_o !== 8'h00) begin n_err++; $display("FAIL rst_tx_tdata: got %h, required 00", tx_tdata_o); end
    if (busy_o !== 1'b0)      begin n_err++; $display("FAIL rst_busy: got %b, required 0", busy_o); end
    if (bad_op_o !== 1'b0)    begin n_err++; $display("FAIL rst_bad_op: got %b, required 0", bad_op_o); end
    reset_i = 1'b0;
    cycle(1'b0);
    n_vec += 2;
    if (rx_tready_o !== 1'b1) begin n_err++; $display("FAIL idle_rx_tready: got %b, required 1", rx_tready_o); end
    if (busy_o !== 1'b0)      begin n_err++; $display("FAIL idle_busy: got %b, required 0", busy_o); end
  endtask

  task automatic test_echo();
    pkt_q = '{8'hEC, 8'h00, 8'h08, 8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    exp_q = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    run_packet();
    n_vec++;
    if (got_q.size() != exp_q.size()) begin n_err++; $display("FAIL echo_count: got %0d bytes, required %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_vec++;
      if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL echo_byte[%0d]: got %h, required %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_add();
    logic [7:0] e[4][$];
    e[0] = '{8'h0C, 8'h00, 8'h00, 8'h00};
    e[1] = '{8'h01, 8'h00, 8'h00, 8'h00};
    e[2] = '{8'h00, 8'h00, 8'h00, 8'h00};
    e[3] = '{8'h04, 8'h03, 8'h02, 8'h01};
    for (int c = 0; c < 4; c++) begin
      case (c)
        0: pkt_q = '{8'h01, 8'h00, 8'h0C, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h07, 8'h00, 8'h00, 8'h00};
        1: pkt_q = '{8'h01, 8'h00, 8'h0C, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h02, 8'h00, 8'h00, 8'h00};
        2: pkt_q = '{8'h01, 8'h00, 8'h04, 8'h00};
        default: pkt_q = '{8'h01, 8'h00, 8'h0A, 8'h00, 8'h04, 8'h03, 8'h02, 8'h01, 8'hAA, 8'hBB};
      endcase
      exp_q = e[c];
      run_packet();
      n_vec += 2;
      if (got_q.size() != 4) begin n_err++; $display("FAIL add%0d_count: got %0d bytes, required 4", c, got_q.size()); end
      if (bad_cnt != 0) begin n_err++; $display("FAIL add%0d_bad_op: got %0d pulses, required 0", c, bad_cnt); end
      for (int i = 0; i < got_q.size() && i < 4; i++) begin
        n_vec++;
        if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL add%0d_byte[%0d]: got %h, required %h", c, i, got_q[i], exp_q[i]); end
      end
    end
  endtask

  task automatic test_backpressure();
    rdy_mode = 1;
    pkt_q = '{8'hEC, 8'h00, 8'h07, 8'h00, 8'h11, 8'h22, 8'h33};
    exp_q = '{8'h11, 8'h22, 8'h33};
    run_packet();
    rdy_mode = 0;
    n_vec++;
    if (got_q.size() != 3) begin n_err++; $display("FAIL bp_count: got %0d bytes, required 3", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < 3; i++) begin
      n_vec++;
      if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL bp_byte[%0d]: got %h, required %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_bad_op();
    pkt_q = '{8'h55, 8'h00, 8'h06, 8'h00, 8'hAA, 8'hBB};
    run_packet();
    n_vec += 2;
    if (bad_cnt != 1) begin n_err++; $display("FAIL badop_pulse: got %0d pulses, required 1", bad_cnt); end
    if (got_q.size() != 0) begin n_err++; $display("FAIL badop_output: got %0d bytes, required 0", got_q.size()); end
    pkt_q = '{8'h55, 8'h00, 8'h02, 8'h00};
    run_packet();
    n_vec++;
    if (bad_cnt != 0) begin n_err++; $display("FAIL badop_short_pulse: got %0d pulses, required 0", bad_cnt); end
    pkt_q = '{8'h01, 8'h00, 8'h0C, 8'h00, 8'h64, 8'h00, 8'h00, 8'h00, 8'hC8, 8'h00, 8'h00, 8'h00};
    exp_q = '{8'h2C, 8'h01, 8'h00, 8'h00};
    run_packet();
    n_vec += 2;
    if (bad_cnt != 0) begin n_err++; $display("FAIL badop_next_pulse: got %0d pulses, required 0", bad_cnt); end
    if (got_q.size() != 4) begin n_err++; $display("FAIL badop_next_count: got %0d bytes, required 4", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < 4; i++) begin
      n_vec++;
      if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL badop_next_byte[%0d]: got %h, required %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_mid();
    got_q.delete();
    pkt_q = '{8'h01, 8'h00, 8'h0C, 8'h00, 8'h05, 8'h00};
    foreach (pkt_q[i]) send_byte(pkt_q[i]);
    reset_i = 1'b1;
    repeat (2) cycle(1'b0);
    reset_i = 1'b0;
    repeat (3) cycle(1'b0);
    n_vec += 2;
    if (busy_o !== 1'b0 || tx_tvalid_o !== 1'b0) begin
      n_err++; $display("FAIL rstmid_idle: busy=%b tx_valid=%b, required 0 0", busy_o, tx_tvalid_o);
    end
    if (got_q.size() != 0) begin n_err++; $display("FAIL rstmid_stale: got %0d bytes, required 0", got_q.size()); end
    pkt_q = '{8'hEC, 8'h00, 8'h06, 8'h00, 8'h5A, 8'hA5};
    exp_q = '{8'h5A, 8'hA5};
    run_packet();
    n_vec++;
    if (got_q.size() != 2) begin n_err++; $display("FAIL rstmid_echo_count: got %0d bytes, required 2", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < 2; i++) begin
      n_vec++;
      if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL rstmid_echo_byte[%0d]: got %h, required %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_sub();
    int want_bad;
    pkt_q = '{8'h02, 8'h00, 8'h0C, 8'h00, 8'h0A, 8'h00, 8'h00, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00};
`ifdef ALU_SUB_EN
    exp_q = '{8'h07, 8'h00, 8'h00, 8'h00};
    want_bad = 0;
`else
    exp_q.delete();
    want_bad = 1;
`endif
    run_packet();
    n_vec += 2;
    if (bad_cnt != want_bad) begin n_err++; $display("FAIL sub_bad_op: got %0d pulses, required %0d", bad_cnt, want_bad); end
    if (got_q.size() != exp_q.size()) begin n_err++; $display("FAIL sub_count: got %0d bytes, required %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_vec++;
      if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL sub_byte[%0d]: got %h, required %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_random();
    logic [7:0]  op;
    logic [15:0] len;
    int          pay;
    for (int n = 0; n < 30; n++) begin
      rdy_mode = $urandom_range(0, 2);
      case ($urandom_range(0, 3))
        0:       op = 8'hEC;
        1:       op = 8'h01;
        2:       op = 8'h02;
        default: op = 8'($urandom_range(3, 255));
      endcase
      len = 16'($urandom_range(0, 22));
      pay = (len < 16'd4) ? 0 : int'(len) - 4;
      pkt_q.delete();
      pkt_q.push_back(op);
      pkt_q.push_back(8'($urandom));
      pkt_q.push_back(len[7:0]);
      pkt_q.push_back(len[15:8]);
      for (int i = 0; i < pay; i++) pkt_q.push_back(8'($urandom));
      build_expected();
      run_packet();
      n_vec += 2;
      if (bad_cnt != exp_bad) begin n_err++; $display("FAIL rnd%0d_bad_op: op=%h got %0d pulses, required %0d", n, op, bad_cnt, exp_bad); end
      if (got_q.size() != exp_q.size()) begin
        n_err++; $display("FAIL rnd%0d_count: op=%h len=%0d got %0d bytes, required %0d", n, op, len, got_q.size(), exp_q.size());
      end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
        n_vec++;
        if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL rnd%0d_byte[%0d]: op=%h got %h, required %h", n, i, op, got_q[i], exp_q[i]); end
      end
    end
    rdy_mode = 0;
  endtask

  initial begin
    n_vec       = 0;
    n_err       = 0;
    cyc         = 0;
    rdy_mode    = 0;
    bad_cnt     = 0;
    exp_bad     = 0;
    hold_prev   = 1'b0;
    hold_data   = 8'h00;
    reset_i     = 1'b1;
    rx_tdata_i  = 8'h00;
    rx_tvalid_i = 1'b0;
    tx_tready_i = 1'b1;
    @(negedge clk_i);
    test_reset();
    test_echo();
    test_add();
    test_backpressure();
    test_bad_op();
    test_reset_mid();
    test_sub();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
